regfile_mp: RTL

Parametrised multi-read, dual-write register file for the next-generation CPU datapath.
- Replaces fixed 16x32 high/low write modes with per-lane write masks.
- Write port A serves the ALU; write port B serves memory/long-latency writeback.
- Adds read-after-write bypass and a busy scoreboard, so decode can stall on registers that still have a long-latency write pending.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_mp_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, mask type and the lane-merge helper used by both the
// register array write path and the read bypass path of regfile_mp.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANE_W = 16;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_LANES  = DEF_DATA_W / DEF_LANE_W;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_W = 256;

  typedef logic [DEF_LANES-1:0] lane_mask_t;
  typedef logic [MERGE_W-1:0]   merge_word_t;

  // Bit b takes data[b] when the lane that owns it (b / lane_w) is enabled.
  function automatic merge_word_t lane_merge(input merge_word_t old_val,
                                             input merge_word_t data,
                                             input merge_word_t mask,
                                             input int          lane_w);
    merge_word_t res;
    logic [7:0]  bi;
    logic [7:0]  li;
    res = old_val;
    for (int b = 0; b < MERGE_W; b++) begin
      bi = 8'(b);
      li = 8'(b / lane_w);
      res[bi] = mask[li] ? data[bi] : old_val[bi];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy scoreboard: one flop per register, set by reservations, cleared by
// port-B writeback, plus a sticky flag for reservations on busy registers.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [DEPTH-1:0]  busy,
  output logic              rsv_err
);

  logic [DEPTH-1:0] busy_next;
  logic             rsv_live;
  logic             err_next;

  // Register 0 cannot be reserved when it is hardwired to zero.
  assign rsv_live = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_busy
    logic set_hit;
    logic clr_hit;
    assign set_hit = rsv_live && (rsv_addr == ADDR_W'(gi));
    assign clr_hit = wb_en && (wb_addr == ADDR_W'(gi));
    // A same-cycle reservation outranks the retiring writeback.
    assign busy_next[gi] = set_hit | (busy[gi] & ~clr_hit);
  end

  assign err_next = rsv_err |
                    (rsv_live && busy[rsv_addr] && !(wb_en && (wb_addr == rsv_addr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      rsv_err <= 1'b0;
    end else begin
      busy    <= busy_next;
      rsv_err <= err_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with per-lane write masks, optional
// same-cycle write bypass and a busy scoreboard for long-latency writes.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NUM_RD   = 2,
  parameter  int LANE_W   = DEF_LANE_W,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int LANES    = DATA_W / LANE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [LANES-1:0]         wa_mask,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [LANES-1:0]         wb_mask,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready,
  output logic                     rsv_err
);

  function automatic logic [DATA_W-1:0] merge_fn(input logic [DATA_W-1:0] old_val,
                                                 input logic [DATA_W-1:0] data,
                                                 input logic [LANES-1:0]  mask);
    return DATA_W'(lane_merge(merge_word_t'(old_val), merge_word_t'(data),
                              merge_word_t'(mask), LANE_W));
  endfunction

  logic [DATA_W-1:0] mem       [DEPTH];
  logic [DATA_W-1:0] word_next [DEPTH];
  logic [DEPTH-1:0]  busy;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_word
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign word_next[gi] = '0;
    end else begin : g_live
      logic [LANES-1:0]  mask_a;
      logic [LANES-1:0]  mask_b;
      assign mask_a = (wa_en && (wa_addr == ADDR_W'(gi))) ? wa_mask : '0;
      assign mask_b = (wb_en && (wb_addr == ADDR_W'(gi))) ? wb_mask : '0;
      // Port B is applied last so it wins on lanes both ports enable.
      assign word_next[gi] = merge_fn(merge_fn(mem[gi], wa_data, mask_a), wb_data, mask_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= word_next[i];
    end
  end

  for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] fwd;
    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
    if (BYPASS != 0) begin : g_byp
      logic [LANES-1:0] byp_a;
      logic [LANES-1:0] byp_b;
      // Gated by rst_n so nothing leaks through while the array is held clear.
      assign byp_a = (rst_n && wa_en && (wa_addr == addr)) ? wa_mask : '0;
      assign byp_b = (rst_n && wb_en && (wb_addr == addr)) ? wb_mask : '0;
      assign fwd   = merge_fn(merge_fn(mem[addr], wa_data, byp_a), wb_data, byp_b);
    end else begin : g_stored
      assign fwd = mem[addr];
    end
    assign rd_data[gi*DATA_W +: DATA_W] = ((ZERO_REG != 0) && (addr == '0)) ? '0 : fwd;
    assign rd_busy[gi] = busy[addr];
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .busy     (busy),
    .rsv_err  (rsv_err)
  );

  assign rsv_ready = ~busy[rsv_addr];

endmodule
